max7219_frame_ctrl: RTL and testbench

// Sequencer in front of the MAX7219 SPI word serializer. After reset it issues the

---
 rtl/max7219_frame_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_max7219_frame_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_frame_ctrl.sv
// ============================================================================
// max7219_frame_ctrl
//   Word sequencer for a MAX7219 SPI serializer: init, frame refresh, intensity.
//   Revision 1.0
// ============================================================================
`default_nettype none

module max7219_frame_ctrl #(
  parameter logic [3:0]  INIT_INTENSITY = 4'h8,
  parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
  parameter logic [15:0] REFRESH_DIV    = 16'd50000,
  parameter logic [7:0]  PWRUP_WAIT     = 8'd100,
  parameter logic [7:0]  ACK_TIMEOUT    = 8'd64
) (
  input  logic        clk_spi,
  input  logic        _rst,
  input  logic [63:0] fb,
  input  logic        frame_wr,
  input  logic [3:0]  cfg_intensity,
  input  logic        cfg_wr,
  input  logic        busy,
  output logic        str,
  output logic [7:0]  IRreg,
  output logic [7:0]  data,
  output logic        init_done,
  output logic        frame_done,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_PWRUP     = 3'd0,
    S_INIT      = 3'd1,
    S_IDLE      = 3'd2,
    S_SNAP      = 3'd3,
    S_ISSUE     = 3'd4,
    S_WAIT_ACK  = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_NEXT      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    K_INIT = 2'd0,
    K_ROW  = 2'd1,
    K_INT  = 2'd2
  } kind_t;

  state_t      r_state;
  kind_t       r_kind;
  logic [2:0]  r_init_idx;
  logic [2:0]  r_row;
  logic [63:0] r_snap;
  logic [7:0]  r_pwr_cnt;
  logic [7:0]  r_ack_cnt;
  logic [15:0] r_timer;
  logic        r_int_pend;
  logic [3:0]  r_int_val;
  logic        r_frame_pend;
  logic        r_in_frame;

  logic [7:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_timer_hit;
  logic        w_pwr_done;
  logic        w_ack_expired;

  always_comb begin
    w_addr = 8'h00;
    w_data = 8'h00;
    case (r_kind)
      K_INIT: begin
        case (r_init_idx)
          3'd0:    begin w_addr = 8'h0F; w_data = 8'h00; end
          3'd1:    begin w_addr = 8'h09; w_data = 8'h00; end
          3'd2:    begin w_addr = 8'h0B; w_data = {5'b0, SCAN_LIMIT}; end
          3'd3:    begin w_addr = 8'h0A; w_data = {4'b0, INIT_INTENSITY}; end
          default: begin w_addr = 8'h0C; w_data = 8'h01; end
        endcase
      end
      K_ROW: begin
        w_addr = {5'b0, r_row} + 8'd1;
        w_data = r_snap[{r_row, 3'b000} +: 8];
      end
      K_INT: begin
        w_addr = 8'h0A;
        w_data = {4'b0, r_int_val};
      end
      default: begin
        w_addr = 8'h00;
        w_data = 8'h00;
      end
    endcase
  end

  // Timer saturates at its terminal count so an expiry missed while busy is
  // still honoured once the sequencer returns to idle.
  assign w_timer_hit   = (REFRESH_DIV != 16'd0) && (r_timer >= REFRESH_DIV - 16'd1);
  assign w_pwr_done    = ({1'b0, r_pwr_cnt} + 9'd1) >= {1'b0, PWRUP_WAIT};
  assign w_ack_expired = ({1'b0, r_ack_cnt} + 9'd1) >= {1'b0, ACK_TIMEOUT};

  always_ff @(posedge clk_spi or negedge _rst) begin
    if (!_rst) begin
      r_state      <= S_PWRUP;
      r_kind       <= K_INIT;
      r_init_idx   <= 3'd0;
      r_row        <= 3'd0;
      r_snap       <= 64'd0;
      r_pwr_cnt    <= 8'd0;
      r_ack_cnt    <= 8'd0;
      r_timer      <= 16'd0;
      r_int_pend   <= 1'b0;
      r_int_val    <= 4'd0;
      r_frame_pend <= 1'b0;
      r_in_frame   <= 1'b0;
      str          <= 1'b0;
      IRreg        <= 8'h00;
      data         <= 8'h00;
      init_done    <= 1'b0;
      frame_done   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!w_timer_hit) r_timer <= r_timer + 16'd1;

      case (r_state)
        S_PWRUP: begin
          if (w_pwr_done) begin
            r_state    <= S_INIT;
            r_init_idx <= 3'd0;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 8'd1;
          end
        end
        S_INIT: begin
          r_kind  <= K_INIT;
          r_state <= S_ISSUE;
        end
        S_IDLE: begin
          if (r_int_pend) begin
            r_kind  <= K_INT;
            r_state <= S_ISSUE;
          end else if (r_frame_pend || w_timer_hit) begin
            r_state <= S_SNAP;
          end
        end
        S_SNAP: begin
          r_snap       <= fb;
          r_row        <= 3'd0;
          r_frame_pend <= 1'b0;
          r_timer      <= 16'd0;
          r_kind       <= K_ROW;
          r_in_frame   <= 1'b1;
          r_state      <= S_ISSUE;
        end
        S_ISSUE: begin
          IRreg     <= w_addr;
          data      <= w_data;
          str       <= 1'b1;
          r_ack_cnt <= 8'd0;
          if (r_kind == K_INT) r_int_pend <= 1'b0;
          r_state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (busy) begin
            str     <= 1'b0;
            r_state <= S_WAIT_DONE;
          end else if (w_ack_expired) begin
            // Drop str for one cycle, then ISSUE re-presents the same word.
            err_timeout <= 1'b1;
            str         <= 1'b0;
            r_state     <= S_ISSUE;
          end else begin
            r_ack_cnt <= r_ack_cnt + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!busy) begin
            r_state <= S_NEXT;
            if (r_kind == K_INIT && r_init_idx == 3'd4) init_done <= 1'b1;
            if (r_kind == K_ROW && r_row == 3'd7) frame_done <= 1'b1;
          end
        end
        S_NEXT: begin
          case (r_kind)
            K_INIT: begin
              if (r_init_idx == 3'd4) begin
                r_state <= S_SNAP;
              end else begin
                r_init_idx <= r_init_idx + 3'd1;
                r_state    <= S_ISSUE;
              end
            end
            K_INT: begin
              if (r_in_frame) begin
                r_kind  <= K_ROW;
                r_row   <= r_row + 3'd1;
                r_state <= S_ISSUE;
              end else begin
                r_state <= S_IDLE;
              end
            end
            default: begin
              if (r_row == 3'd7) begin
                r_in_frame <= 1'b0;
                r_state    <= S_IDLE;
              end else if (r_int_pend) begin
                r_kind  <= K_INT;
                r_state <= S_ISSUE;
              end else begin
                r_row   <= r_row + 3'd1;
                r_state <= S_ISSUE;
              end
            end
          endcase
        end
        default: r_state <= S_PWRUP;
      endcase

      // Request capture comes last so a new pulse beats a same-cycle clear.
      if (frame_wr) r_frame_pend <= 1'b1;
      if (cfg_wr) begin
        r_int_pend <= 1'b1;
        r_int_val  <= cfg_intensity;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_max7219_frame_ctrl.sv
// ============================================================================
// tb_max7219_frame_ctrl
//   Directed bench for max7219_frame_ctrl with a simple serializer busy model.
//   Revision 1.0
// ============================================================================
`default_nettype none

module tb_max7219_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] fb;
  logic        frame_wr;
  logic [3:0]  cfg_intensity;
  logic        cfg_wr;
  logic        busy;
  logic        str;
  logic [7:0]  IRreg;
  logic [7:0]  data;
  logic        init_done;
  logic        frame_done;
  logic        err_timeout;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] words[$];
  int          frame_cnt = 0;
  logic        prev_str = 1'b0;
  logic        busy_en = 1'b1;

  max7219_frame_ctrl dut (
    .clk_spi      (clk),
    ._rst         (rst_n),
    .fb           (fb),
    .frame_wr     (frame_wr),
    .cfg_intensity(cfg_intensity),
    .cfg_wr       (cfg_wr),
    .busy         (busy),
    .str          (str),
    .IRreg        (IRreg),
    .data         (data),
    .init_done    (init_done),
    .frame_done   (frame_done),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  // Word log: one entry per rising edge of str, plus frame_done pulse count.
  always @(negedge clk) begin
    if (str && !prev_str) words.push_back({IRreg, data});
    prev_str <= str;
    if (frame_done) frame_cnt <= frame_cnt + 1;
  end

  // Serializer model: busy rises 2 cycles after str is seen, stays 16 cycles.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (str && busy_en) begin
        repeat (2) @(negedge clk);
        busy = 1'b1;
        repeat (16) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_words(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (words.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (frame_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk) frame_wr = 1'b1;
    @(negedge clk) frame_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fb = 64'd0; frame_wr = 1'b0; cfg_wr = 1'b0; cfg_intensity = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({str, IRreg, data} !== 17'd0) begin
      n_fail++; $display("FAIL reset_word: got %h required 0", {str, IRreg, data});
    end
    n_checks++;
    if ({init_done, frame_done, err_timeout} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {init_done, frame_done, err_timeout});
    end
    n_checks++;
    if (words.size() != 0) begin
      n_fail++; $display("FAIL reset_no_words: got %0d required 0", words.size());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [15:0] exp_t [5] = '{16'h0F00, 16'h0900, 16'h0B07, 16'h0A08, 16'h0C01};
    bit ok;
    wait_words(5, 3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL init_timeout: got %0d words required 5", words.size()); end
    n_checks++;
    if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_done_early: got %b required 0", init_done); end
    wait_frames(1, 3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL init_frame_timeout: got %0d frames required 1", frame_cnt); end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (words[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL init_word%0d: got %h required %h", i, words[i], exp_t[i]);
      end
    end
    n_checks++;
    if (words.size() != 13) begin n_fail++; $display("FAIL init_word_count: got %0d required 13", words.size()); end
    n_checks++;
    if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b required 1", init_done); end
  endtask

  task automatic test_frame();
    int f0;
    bit ok;
    logic [7:0] e;
    words.delete();
    f0 = frame_cnt;
    fb = 64'h8040201008040201;
    pulse_frame();
    wait_frames(f0 + 1, 1000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL frame_timeout: got %0d frames required %0d", frame_cnt, f0 + 1); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (words.size() != 8) begin n_fail++; $display("FAIL frame_word_count: got %0d required 8", words.size()); end
    for (int i = 0; i < 8; i++) begin
      e = 8'h01 << i;
      n_checks++;
      if (words[i] !== {8'(i + 1), e}) begin
        n_fail++; $display("FAIL frame_word%0d: got %h required %h", i, words[i], {8'(i + 1), e});
      end
    end
    n_checks++;
    if (frame_cnt != f0 + 1) begin n_fail++; $display("FAIL frame_done_count: got %0d required %0d", frame_cnt, f0 + 1); end
  endtask

  task automatic test_intensity();
    logic [15:0] exp_t [9] = '{16'h0101, 16'h0202, 16'h0304, 16'h0408, 16'h0A03,
                               16'h0510, 16'h0620, 16'h0740, 16'h0880};
    int f0;
    bit ok;
    words.delete();
    f0 = frame_cnt;
    pulse_frame();
    wait_words(4, 500, ok);
    repeat (3) @(negedge clk);
    cfg_intensity = 4'h5; cfg_wr = 1'b1;
    @(negedge clk) cfg_wr = 1'b0;
    @(negedge clk) begin cfg_intensity = 4'h3; cfg_wr = 1'b1; end
    @(negedge clk) cfg_wr = 1'b0;
    wait_frames(f0 + 1, 1000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL int_timeout: got %0d frames required %0d", frame_cnt, f0 + 1); end
    repeat (60) @(negedge clk);
    n_checks++;
    if (words.size() != 9) begin n_fail++; $display("FAIL int_word_count: got %0d required 9", words.size()); end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (words[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL int_word%0d: got %h required %h", i, words[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_t [8] = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] b_t [8] = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
    int f0;
    bit ok;
    words.delete();
    f0 = frame_cnt;
    fb = 64'h1122334455667788;
    pulse_frame();
    wait_words(2, 500, ok);
    for (int k = 0; k < 3; k++) begin
      pulse_frame();
      repeat (2) @(negedge clk);
    end
    wait_words(3, 500, ok);
    fb = 64'hF0E0D0C0B0A09080;
    wait_frames(f0 + 2, 2000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d frames required %0d", frame_cnt, f0 + 2); end
    repeat (250) @(negedge clk);
    n_checks++;
    if (words.size() != 16) begin n_fail++; $display("FAIL b2b_word_count: got %0d required 16", words.size()); end
    n_checks++;
    if (frame_cnt != f0 + 2) begin n_fail++; $display("FAIL b2b_frames: got %0d required %0d", frame_cnt, f0 + 2); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (words[i] !== {8'(i + 1), a_t[i]}) begin
        n_fail++; $display("FAIL b2b_first%0d: got %h required %h", i, words[i], {8'(i + 1), a_t[i]});
      end
      n_checks++;
      if (words[i + 8] !== {8'(i + 1), b_t[i]}) begin
        n_fail++; $display("FAIL b2b_extra%0d: got %h required %h", i, words[i + 8], {8'(i + 1), b_t[i]});
      end
    end
  endtask

  task automatic test_timeout();
    int f0;
    int n;
    bit ok;
    busy_en = 1'b0;
    words.delete();
    f0 = frame_cnt;
    fb = 64'h5500000000000000;
    pulse_frame();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (str) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_str_rise: got str=%b required 1", str); end
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != 64) begin n_fail++; $display("FAIL to_latency: got %0d cycles required 64", n); end
    wait_words(2, 100, ok);
    n_checks++;
    if (!ok || words[1] !== 16'h0100 || words[0] !== 16'h0100) begin
      n_fail++; $display("FAIL to_reissue: got %h,%h required 0100,0100", words[0], words[1]);
    end
    busy_en = 1'b1;
    wait_frames(f0 + 1, 1000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL to_recover: got %0d frames required %0d", frame_cnt, f0 + 1); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (words[words.size() - 1] !== 16'h0855) begin
      n_fail++; $display("FAIL to_last_word: got %h required 0855", words[words.size() - 1]);
    end
    n_checks++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b required 1", err_timeout); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] exp_t [5] = '{16'h0F00, 16'h0900, 16'h0B07, 16'h0A08, 16'h0C01};
    int f0;
    bit ok;
    words.delete();
    fb = 64'h8040201008040201;
    pulse_frame();
    wait_words(5, 500, ok);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (str !== 1'b0) begin n_fail++; $display("FAIL rst_str_async: got %b required 0", str); end
    n_checks++;
    if ({init_done, err_timeout} !== 2'b00) begin
      n_fail++; $display("FAIL rst_flags_async: got %b required 00", {init_done, err_timeout});
    end
    words.delete();
    f0 = frame_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frames(f0 + 1, 3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rst_reinit_timeout: got %0d frames required %0d", frame_cnt, f0 + 1); end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (words[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL rst_init_word%0d: got %h required %h", i, words[i], exp_t[i]);
      end
    end
    n_checks++;
    if (words[12] !== 16'h0880) begin n_fail++; $display("FAIL rst_frame_last: got %h required 0880", words[12]); end
    n_checks++;
    if (init_done !== 1'b1) begin n_fail++; $display("FAIL rst_init_done: got %b required 1", init_done); end
  endtask

  initial begin
    rst_n = 1'b0;
    fb = 64'd0;
    frame_wr = 1'b0;
    cfg_wr = 1'b0;
    cfg_intensity = 4'h0;
    test_reset();
    test_init();
    test_frame();
    test_intensity();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
